// File: rtl/prx32_pkg.sv
// prx32_pkg: shared constants, port id type and address check
// for the prx32 ROM arbiter slice.
package prx32_pkg;

    localparam int MEM_DEPTH = 1024;
    localparam int ROM_BYTES = 4096;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    function automatic logic addr_ok(input logic [31:0] addr);
        return (addr[1:0] == 2'b00) && (addr < 32'(ROM_BYTES));
    endfunction

endpackage

// File: rtl/prx32_rom_arbiter_if.sv
// prx32_rom_arbiter_if: two-requester ROM bus plus ROM side
// and debug counters, with requester (master) and arbiter (slave) views.
interface prx32_rom_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0;
    logic             req1;
    logic [31:0]      addr0;
    logic [31:0]      addr1;
    logic             gnt0;
    logic             gnt1;
    logic             rvalid0;
    logic             rvalid1;
    logic [31:0]      rdata0;
    logic [31:0]      rdata1;
    logic             rerr;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;
    logic [CNT_W-1:0] conflict_cnt;

    modport slave (
        input  req0, req1, addr0, addr1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1,
        output rdata0, rdata1, rerr, mem_addr,
        output gnt_cnt0, gnt_cnt1, conflict_cnt
    );

    modport master (
        output req0, req1, addr0, addr1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1,
        input  rdata0, rdata1, rerr, mem_addr,
        input  gnt_cnt0, gnt_cnt1, conflict_cnt
    );

endinterface

// File: rtl/prx32_rr_arbiter.sv
// prx32_rr_arbiter: 2-way arbiter, round-robin or fixed port-0 priority.
// last_q names the port that wins the next tie.
module prx32_rr_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    import prx32_pkg::*;

    port_id_t last_q;
    port_id_t last_d;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if ((FIXED_PRIO != 0) || (last_q == PORT0)) gnt = 2'b01;
                else                                        gnt = 2'b10;
            end
            default: gnt = 2'b00;
        endcase
    end

    // Point at the port that lost (or was idle) on this grant.
    always_comb begin
        last_d = last_q;
        if (gnt[0])      last_d = PORT1;
        else if (gnt[1]) last_d = PORT0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= PORT0;
        else        last_q <= last_d;
    end

endmodule

// File: rtl/prx32_rom_arbiter.sv
// prx32_rom_arbiter: shares the one-cycle ROM between fetch (port 0)
// and hex-dump (port 1); data returns to its owner one cycle after grant.
module prx32_rom_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    prx32_rom_arbiter_if.slave bus
);
    import prx32_pkg::*;

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             any_gnt;
    logic [31:0]      gnt_addr;

    logic [31:0]      mem_addr_q, mem_addr_d;
    logic             rsp_v_q, rsp_v_d;
    port_id_t         rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;
    logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] c,
        input logic             en
    );
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    // Masking requests keeps every grant low while reset is held.
    assign req = {bus.req1, bus.req0} & {2{rst_n}};

    prx32_rr_arbiter #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt)
    );

    assign any_gnt  = |gnt;
    assign gnt_addr = gnt[1] ? bus.addr1 : bus.addr0;

    always_comb begin
        mem_addr_d     = mem_addr_q;
        rsp_v_d        = any_gnt;
        rsp_id_d       = rsp_id_q;
        rsp_err_d      = rsp_err_q;
        gnt_cnt0_d     = sat_inc(gnt_cnt0_q, gnt[0]);
        gnt_cnt1_d     = sat_inc(gnt_cnt1_q, gnt[1]);
        conflict_cnt_d = sat_inc(conflict_cnt_q, &req);
        if (any_gnt) begin
            mem_addr_d = gnt_addr;
            rsp_id_d   = gnt[1] ? PORT1 : PORT0;
            rsp_err_d  = ~addr_ok(gnt_addr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q     <= '0;
            rsp_v_q        <= 1'b0;
            rsp_id_q       <= PORT0;
            rsp_err_q      <= 1'b0;
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            mem_addr_q     <= mem_addr_d;
            rsp_v_q        <= rsp_v_d;
            rsp_id_q       <= rsp_id_d;
            rsp_err_q      <= rsp_err_d;
            gnt_cnt0_q     <= gnt_cnt0_d;
            gnt_cnt1_q     <= gnt_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // The ROM sees the granted address in the grant cycle itself.
    assign bus.mem_addr = mem_addr_d;

    assign bus.gnt0    = gnt[0];
    assign bus.gnt1    = gnt[1];
    assign bus.rvalid0 = rsp_v_q & (rsp_id_q == PORT0);
    assign bus.rvalid1 = rsp_v_q & (rsp_id_q == PORT1);
    assign bus.rerr    = rsp_v_q & rsp_err_q;
    assign bus.rdata0  = (bus.rvalid0 && !rsp_err_q) ? bus.mem_rdata : '0;
    assign bus.rdata1  = (bus.rvalid1 && !rsp_err_q) ? bus.mem_rdata : '0;

    assign bus.gnt_cnt0     = gnt_cnt0_q;
    assign bus.gnt_cnt1     = gnt_cnt1_q;
    assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_prx32_rom_arbiter.sv
// tb_prx32_rom_arbiter: round-robin and fixed-priority instances against
// a behavioural ROM and a per-cycle reference model.
`timescale 1ns/1ps
module tb_prx32_rom_arbiter;
    import prx32_pkg::*;

    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prx32_rom_arbiter_if #(.CNT_W(CNT_W)) bus ();
    prx32_rom_arbiter_if #(.CNT_W(CNT_W)) bus_fp ();

    prx32_rom_arbiter #(.FIXED_PRIO(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    prx32_rom_arbiter #(.FIXED_PRIO(1), .CNT_W(CNT_W)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus_fp)
    );

    logic [31:0] rom [MEM_DEPTH];

    always @(posedge clk) begin
        bus.mem_rdata    <= rom[bus.mem_addr[11:2]];
        bus_fp.mem_rdata <= rom[bus_fp.mem_addr[11:2]];
    end

    int vectors = 0;
    int errors  = 0;

    // Reference model for the round-robin instance.
    int          m_last;
    bit          m_pv;
    int          m_pport;
    bit          m_perr;
    logic [31:0] m_paddr;
    logic [31:0] m_maddr;
    int          m_c0, m_c1, m_cc;

    task automatic model_reset();
        m_last  = 1;
        m_pv    = 1'b0;
        m_pport = 0;
        m_perr  = 1'b0;
        m_paddr = '0;
        m_maddr = '0;
        m_c0 = 0; m_c1 = 0; m_cc = 0;
    endtask

    function automatic int winner(bit r0, bit r1);
        if (r0 && r1) return (m_last == 0) ? 1 : 0;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    task automatic model_commit();
        int w;
        logic [31:0] a;
        w = winner(bus.req0, bus.req1);
        if (bus.req0 && bus.req1 && m_cc < CMAX) m_cc++;
        m_pv = (w >= 0);
        if (w >= 0) begin
            a = (w == 1) ? bus.addr1 : bus.addr0;
            m_last  = w;
            m_pport = w;
            m_paddr = a;
            m_maddr = a;
            m_perr  = (a % 4 != 0) || (a >= 4096);
            if (w == 0 && m_c0 < CMAX) m_c0++;
            if (w == 1 && m_c1 < CMAX) m_c1++;
        end
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit r0, logic [31:0] a0, bit r1, logic [31:0] a1);
        bus.req0 = r0;    bus.addr0 = a0;
        bus.req1 = r1;    bus.addr1 = a1;
        bus_fp.req0 = r0; bus_fp.addr0 = a0;
        bus_fp.req1 = r1; bus_fp.addr1 = a1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h1000 + 32'($urandom_range(0, 255) << 2);
            1:       return {20'h0, 10'($urandom_range(0, 1023)),
                             2'($urandom_range(1, 3))};
            default: return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 32'h4, 1, 32'h8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.gnt0, bus.gnt1, bus_fp.gnt0, bus_fp.gnt1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_gnt: got %b%b%b%b want 0000",
                     bus.gnt0, bus.gnt1, bus_fp.gnt0, bus_fp.gnt1);
        end
        vectors++;
        if ({bus.rvalid0, bus.rvalid1, bus.rerr} !== 3'b0 ||
            bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp: rv0=%b rv1=%b rerr=%b d0=%h d1=%h want 0",
                     bus.rvalid0, bus.rvalid1, bus.rerr, bus.rdata0, bus.rdata1);
        end
        vectors++;
        if (bus.gnt_cnt0 !== '0 || bus.gnt_cnt1 !== '0 ||
            bus.conflict_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got %h %h %h want 0",
                     bus.gnt_cnt0, bus.gnt_cnt1, bus.conflict_cnt);
        end
        vectors++;
        if (bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr);
        end
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        drive(1, 32'h4, 0, 32'h0);
        @(negedge clk);
        vectors++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt: got %b%b want 10", bus.gnt0, bus.gnt1);
        end
        vectors++;
        if (bus.mem_addr !== 32'h4) begin
            errors++;
            $display("FAIL single_mem_addr: got %h want 4", bus.mem_addr);
        end
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.rerr !== 1'b0 ||
            bus.rdata0 !== rom[1]) begin
            errors++;
            $display("FAIL single_rsp: rv0=%b rv1=%b rerr=%b d0=%h want 1 0 0 %h",
                     bus.rvalid0, bus.rvalid1, bus.rerr, bus.rdata0, rom[1]);
        end
        vectors++;
        if (bus.gnt_cnt0 !== 16'd1) begin
            errors++;
            $display("FAIL single_cnt0: got %0d want 1", bus.gnt_cnt0);
        end
        tick();
    endtask

    task automatic test_conflict();
        int exp_w [4] = '{0, 1, 0, 1};
        logic [31:0] exp_d;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h10, 1, 32'h20);
            @(negedge clk);
            vectors++;
            if (bus.gnt0 !== (exp_w[i] == 0) || bus.gnt1 !== (exp_w[i] == 1)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %b%b want port %0d",
                         i, bus.gnt0, bus.gnt1, exp_w[i]);
            end
            vectors++;
            if (bus_fp.gnt0 !== 1'b1 || bus_fp.gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL fp_order[%0d]: got %b%b want 10",
                         i, bus_fp.gnt0, bus_fp.gnt1);
            end
            if (i > 0) begin
                exp_d = (exp_w[i-1] == 0) ? rom[4] : rom[8];
                vectors++;
                if (bus.rvalid0 !== (exp_w[i-1] == 0) ||
                    bus.rvalid1 !== (exp_w[i-1] == 1) ||
                    (bus.rdata0 | bus.rdata1) !== exp_d) begin
                    errors++;
                    $display("FAIL rr_rsp[%0d]: rv=%b%b d=%h want port %0d %h",
                             i, bus.rvalid0, bus.rvalid1,
                             bus.rdata0 | bus.rdata1, exp_w[i-1], exp_d);
                end
            end
            tick();
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus.rvalid1 !== 1'b1 || bus.rvalid0 !== 1'b0 ||
            bus.rdata1 !== rom[8]) begin
            errors++;
            $display("FAIL rr_last_rsp: rv=%b%b d1=%h want 01 %h",
                     bus.rvalid0, bus.rvalid1, bus.rdata1, rom[8]);
        end
        vectors++;
        if (bus.conflict_cnt !== 16'd4 || bus_fp.conflict_cnt !== 16'd4) begin
            errors++;
            $display("FAIL conflict_cnt: got %0d/%0d want 4",
                     bus.conflict_cnt, bus_fp.conflict_cnt);
        end
        vectors++;
        if (bus.gnt_cnt0 !== 16'd2 || bus.gnt_cnt1 !== 16'd2) begin
            errors++;
            $display("FAIL rr_gnt_cnt: got %0d/%0d want 2/2",
                     bus.gnt_cnt0, bus.gnt_cnt1);
        end
        vectors++;
        if (bus_fp.gnt_cnt0 !== 16'd4 || bus_fp.gnt_cnt1 !== 16'd0) begin
            errors++;
            $display("FAIL fp_gnt_cnt: got %0d/%0d want 4/0",
                     bus_fp.gnt_cnt0, bus_fp.gnt_cnt1);
        end
        tick();
    endtask

    task automatic test_errors();
        drive(0, 0, 1, 32'h1000);
        @(negedge clk);
        vectors++;
        if (bus.gnt1 !== 1'b1 || bus.mem_addr !== 32'h1000) begin
            errors++;
            $display("FAIL err_range_gnt: gnt1=%b addr=%h want 1 1000",
                     bus.gnt1, bus.mem_addr);
        end
        tick();
        drive(0, 0, 1, 32'h2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.rvalid1 !== 1'b1 || bus.rerr !== 1'b1 ||
                bus.rdata1 !== 32'h0 || bus.rvalid0 !== 1'b0) begin
                errors++;
                $display("FAIL err_rsp[%0d]: rv1=%b rerr=%b d1=%h rv0=%b want 1 1 0 0",
                         i, bus.rvalid1, bus.rerr, bus.rdata1, bus.rvalid0);
            end
            if (i == 0) begin
                vectors++;
                if (bus.gnt1 !== 1'b1) begin
                    errors++;
                    $display("FAIL err_align_gnt: got %b want 1", bus.gnt1);
                end
            end
            tick();
            drive(0, 0, 0, 0);
        end
        @(negedge clk);
        vectors++;
        if (bus.rvalid1 !== 1'b0 || bus.rerr !== 1'b0 || bus.mem_addr !== 32'h2) begin
            errors++;
            $display("FAIL err_idle: rv1=%b rerr=%b addr=%h want 0 0 2",
                     bus.rvalid1, bus.rerr, bus.mem_addr);
        end
        tick();
    endtask

    task automatic test_random();
        bit r0 = 0, r1 = 0;
        logic [31:0] a0 = '0, a1 = '0;
        int w;
        logic [31:0] ea, ed0, ed1;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            drive(r0, a0, r1, a1);
            @(negedge clk);
            w   = winner(r0, r1);
            ea  = (w == 0) ? a0 : (w == 1) ? a1 : m_maddr;
            ed0 = (m_pv && m_pport == 0 && !m_perr) ? rom[m_paddr[11:2]] : 32'h0;
            ed1 = (m_pv && m_pport == 1 && !m_perr) ? rom[m_paddr[11:2]] : 32'h0;
            vectors++;
            if (bus.gnt0 !== (w == 0) || bus.gnt1 !== (w == 1) ||
                bus.mem_addr !== ea) begin
                errors++;
                $display("FAIL rand_gnt[%0d]: gnt=%b%b addr=%h want port %0d %h",
                         i, bus.gnt0, bus.gnt1, bus.mem_addr, w, ea);
            end
            vectors++;
            if (bus.rvalid0 !== (m_pv && m_pport == 0) ||
                bus.rvalid1 !== (m_pv && m_pport == 1) ||
                bus.rerr !== (m_pv && m_perr) ||
                bus.rdata0 !== ed0 || bus.rdata1 !== ed1) begin
                errors++;
                $display("FAIL rand_rsp[%0d]: rv=%b%b err=%b d=%h/%h want %b%b %b %h/%h",
                         i, bus.rvalid0, bus.rvalid1, bus.rerr, bus.rdata0,
                         bus.rdata1, m_pv && m_pport == 0, m_pv && m_pport == 1,
                         m_pv && m_perr, ed0, ed1);
            end
            vectors++;
            if (bus.gnt_cnt0 !== CNT_W'(m_c0) || bus.gnt_cnt1 !== CNT_W'(m_c1) ||
                bus.conflict_cnt !== CNT_W'(m_cc)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d %0d %0d want %0d %0d %0d",
                         i, bus.gnt_cnt0, bus.gnt_cnt1, bus.conflict_cnt,
                         m_c0, m_c1, m_cc);
            end
            tick();
            // A requester keeps its request until it has been granted.
            if (!r0 || w == 0) begin
                r0 = ($urandom_range(0, 9) < 7);
                a0 = rand_addr();
            end
            if (!r1 || w == 1) begin
                r1 = ($urandom_range(0, 9) < 7);
                a1 = rand_addr();
            end
        end
        drive(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(0, 0, 1, 32'h40);
        @(negedge clk);
        vectors++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt1: got %b want 1", bus.gnt1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1, 32'h8, 1, 32'h10);
        @(negedge clk);
        vectors++;
        if (bus.rvalid1 !== 1'b0 || bus.rerr !== 1'b0 || bus.rdata1 !== 32'h0 ||
            bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_drop: rv1=%b rerr=%b d1=%h gnt=%b%b want all 0",
                     bus.rvalid1, bus.rerr, bus.rdata1, bus.gnt0, bus.gnt1);
        end
        vectors++;
        if (bus.gnt_cnt0 !== '0 || bus.gnt_cnt1 !== '0 || bus.conflict_cnt !== '0) begin
            errors++;
            $display("FAIL mid_cnt: got %0d %0d %0d want 0",
                     bus.gnt_cnt0, bus.gnt_cnt1, bus.conflict_cnt);
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_gnt: got %b%b want 10", bus.gnt0, bus.gnt1);
        end
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.rdata0 !== rom[2]) begin
            errors++;
            $display("FAIL mid_rsp: rv=%b%b d0=%h want 10 %h",
                     bus.rvalid0, bus.rvalid1, bus.rdata0, rom[2]);
        end
        tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        drive(1, 32'h0, 0, 32'h0);
        repeat (65534) tick();
        @(negedge clk);
        vectors++;
        if (bus.gnt_cnt0 !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: got %h want fffe", bus.gnt_cnt0);
        end
        repeat (6) tick();
        @(negedge clk);
        vectors++;
        if (bus.gnt_cnt0 !== 16'hFFFF || bus.gnt_cnt0 !== CNT_W'(m_c0)) begin
            errors++;
            $display("FAIL sat_hold: got %h want ffff", bus.gnt_cnt0);
        end
        vectors++;
        if (bus.gnt_cnt1 !== '0 || bus.conflict_cnt !== '0) begin
            errors++;
            $display("FAIL sat_others: got %h %h want 0",
                     bus.gnt_cnt1, bus.conflict_cnt);
        end
        drive(0, 0, 0, 0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) rom[i] = $urandom;
        model_reset();
        drive(0, 0, 0, 0);
        test_reset();
        test_single();
        test_conflict();
        test_errors();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
